// File: rtl/adder_share_ctrl_if.sv
// Request, shared-adder and response signals of adder_share_ctrl.
// The controller connects through slave; the requesters and the adder side connect through master.
interface adder_share_ctrl_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_op;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;

  logic [7:0]        add_a;
  logic [7:0]        add_b;
  logic              add_cin;
  logic [7:0]        add_s;
  logic              add_cout;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_s;
  logic              rsp_cout;
  logic              rsp_ovf;
  logic              busy;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready,
    input  add_a, add_b, add_cin,
    output add_s, add_cout,
    input  rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf, busy,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready,
    output add_a, add_b, add_cin,
    input  add_s, add_cout,
    output rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf, busy,
    input  rsp_ready
  );
endinterface

// File: rtl/adder_share_ctrl.sv
// Round-robin sequencer sharing one combinational 8-bit add/sub unit between NREQ requesters.
// One request is in flight at a time: IDLE (grant) -> EXEC (drive adder) -> RESP (hold result).
module adder_share_ctrl #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input logic              clk,
  input logic              rst_n,
  adder_share_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e         state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] id_q;
  logic [7:0]     add_a_q;
  logic [7:0]     add_b_q;
  logic           add_cin_q;
  logic [7:0]     rsp_s_q;
  logic           rsp_cout_q;
  logic           rsp_ovf_q;
  logic           rsp_valid_q;
  logic           busy_q;

  logic [IDW-1:0] winner;
  logic           found;
  logic [IDW-1:0] idx_w;
  int unsigned    idx;
  logic [NREQ-1:0] grant_vec;
  logic [7:0]     sel_a;
  logic [7:0]     sel_b;
  logic           sel_op;
  logic [IDW-1:0] next_ptr;
  logic           ovf;

  // First valid requester at or above ptr_q, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_w  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx   = (32'(ptr_q) + k) % NREQ;
      idx_w = IDW'(idx);
      if (!found && bus.req_valid[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_op    = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == winner) begin
        grant_vec[i] = 1'b1;
        sel_a        = bus.req_a[i*8 +: 8];
        sel_b        = bus.req_b[i*8 +: 8];
        sel_op       = bus.req_op[i];
      end
    end
  end

  assign bus.req_ready = (state_q == StIdle && found && rst_n) ? grant_vec : '0;

  assign next_ptr = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;

  // Signed overflow: operands agree in sign (B after mode inversion) but the sum does not.
  assign ovf = (add_a_q[7] == (add_b_q[7] ^ add_cin_q)) && (bus.add_s[7] != add_a_q[7]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      id_q        <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      rsp_s_q     <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (found) begin
            add_a_q   <= sel_a;
            add_b_q   <= sel_b;
            add_cin_q <= sel_op;
            id_q      <= winner;
            busy_q    <= 1'b1;
            state_q   <= StExec;
          end
        end
        StExec: begin
          rsp_s_q     <= bus.add_s;
          rsp_cout_q  <= bus.add_cout;
          rsp_ovf_q   <= ovf;
          rsp_valid_q <= 1'b1;
          // The shared unit sees zeros outside EXEC.
          add_a_q     <= '0;
          add_b_q     <= '0;
          add_cin_q   <= 1'b0;
          state_q     <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ptr_q       <= next_ptr;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_cin   = add_cin_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_s     = rsp_s_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl: directed cases plus random traffic against a transaction-level model.
module tb_adder_share_ctrl;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk;
  logic rst_n;
  logic chk_en;
  int   n_checks;
  int   n_errors;

  adder_share_ctrl_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  adder_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared adder: 9-bit result, bit 8 is carry for add and borrow for subtract.
  logic [8:0] sum9;
  assign sum9 = bus.add_cin ? ({1'b0, bus.add_a} - {1'b0, bus.add_b})
                            : ({1'b0, bus.add_a} + {1'b0, bus.add_b});
  assign bus.add_s    = sum9[7:0];
  assign bus.add_cout = sum9[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {ovf, cout, s}.
  function automatic logic [9:0] calc(input logic [7:0] a, input logic [7:0] b, input logic op);
    int ua, ub, sa, sb, r, sr;
    logic cout;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!op) begin
      r = ua + ub; sr = sa + sb; cout = (r > 255);
    end else begin
      r = ua - ub; sr = sa - sb; cout = (ua < ub);
    end
    calc = {(sr > 127 || sr < -128), cout, 8'(r & 255)};
  endfunction

  // Model state: one in-flight transaction, aged 1 (EXEC) or 2 (RESP).
  logic        m_busy;
  int          m_age;
  int          m_ptr;
  int          m_id;
  logic [7:0]  m_a, m_b;
  logic        m_op;
  logic        m_clear;
  logic [NREQ-1:0] e_ready;
  logic [NREQ-1:0] last_ready;
  logic [9:0]  m_r;
  int          w;
  int          cand;

  always @(negedge clk) begin
    e_ready = '0;
    w = -1;
    if (!m_busy && rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = (m_ptr + k) % NREQ;
        if (w < 0 && bus.req_valid[2'(cand)]) w = cand;
      end
    end
    if (w >= 0) e_ready[2'(w)] = 1'b1;
    last_ready = bus.req_ready;
    if (chk_en) begin
      chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_busy && m_age == 2));
      chk("add_a", 32'(bus.add_a), (m_busy && m_age == 1) ? 32'(m_a) : 32'd0);
      chk("add_b", 32'(bus.add_b), (m_busy && m_age == 1) ? 32'(m_b) : 32'd0);
      chk("add_cin", 32'(bus.add_cin), (m_busy && m_age == 1) ? 32'(m_op) : 32'd0);
      if (m_busy && m_age == 2) begin
        m_r = calc(m_a, m_b, m_op);
        chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
        chk("rsp_s", 32'(bus.rsp_s), 32'(m_r[7:0]));
        chk("rsp_cout", 32'(bus.rsp_cout), 32'(m_r[8]));
        chk("rsp_ovf", 32'(bus.rsp_ovf), 32'(m_r[9]));
      end
      if (m_clear && !m_busy)
        chk("rsp_regs_cleared",
            32'({bus.rsp_id, bus.rsp_s, bus.rsp_cout, bus.rsp_ovf}), 32'd0);
    end
    if (!rst_n) begin
      m_busy = 1'b0; m_age = 0; m_ptr = 0; m_clear = 1'b1;
    end else if (!m_busy) begin
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_age   = 1;
        m_id    = w;
        m_a     = bus.req_a[w*8 +: 8];
        m_b     = bus.req_b[w*8 +: 8];
        m_op    = bus.req_op[w];
        m_clear = 1'b0;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (bus.rsp_ready) begin
      m_busy = 1'b0;
      m_ptr  = (m_id + 1) % NREQ;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic op,
                        input logic [7:0] es, input logic ec, input logic eo,
                        input bit scramble, input string nm);
    int n;
    bus.req_a[id*8 +: 8] = a;
    bus.req_b[id*8 +: 8] = b;
    bus.req_op[id]       = op;
    bus.req_valid[id]    = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[id] && n < 20) begin
      tick(); @(negedge clk); n++;
    end
    chk({nm, "_grant"}, 32'(bus.req_ready), 32'(1) << id);
    tick();
    bus.req_valid[id] = 1'b0;
    if (scramble) begin
      bus.req_a[id*8 +: 8] = ~a;
      bus.req_b[id*8 +: 8] = ~b;
      bus.req_op[id]       = ~op;
    end
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 20) begin
      tick(); @(negedge clk); n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'd1);
    chk({nm, "_id"}, 32'(bus.rsp_id), 32'(id));
    chk({nm, "_s"}, 32'(bus.rsp_s), 32'(es));
    chk({nm, "_cout"}, 32'(bus.rsp_cout), 32'(ec));
    chk({nm, "_ovf"}, 32'(bus.rsp_ovf), 32'(eo));
    tick();
  endtask

  task automatic wait_rsp_valid(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 20) begin
      tick(); @(negedge clk); n++;
    end
    chk({nm, "_rsp_seen"}, 32'(bus.rsp_valid), 32'd1);
  endtask

  function automatic logic [7:0] pick8();
    case ($urandom % 6)
      0: pick8 = 8'h00;
      1: pick8 = 8'h7F;
      2: pick8 = 8'h80;
      3: pick8 = 8'hFF;
      default: pick8 = 8'($urandom);
    endcase
  endfunction

  logic [IDW-1:0] ids[$];
  logic [7:0]     hold_s;
  logic [IDW-1:0] hold_id;

  initial begin
    n_checks = 0; n_errors = 0; chk_en = 1'b0;
    m_busy = 1'b0; m_age = 0; m_ptr = 0; m_id = 0; m_clear = 1'b1;
    m_a = '0; m_b = '0; m_op = 1'b0;
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state", 32'({bus.rsp_valid, bus.busy, bus.req_ready, bus.add_a, bus.add_cin}),
        32'd0);

    do_req(0, 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0, 1'b0, "add_200_100");
    do_req(1, 8'd5, 8'd9, 1'b1, 8'hFC, 1'b1, 1'b0, 1'b0, "sub_5_9");
    do_req(1, 8'd9, 8'd5, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, "sub_9_5");
    do_req(1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, "sub_80_01");
    do_req(2, 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1, "isolation");

    // Round robin from a fresh pointer.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*8 +: 8] = pick8();
      bus.req_b[i*8 +: 8] = pick8();
      bus.req_op[i]       = 1'($urandom);
    end
    bus.req_valid = '1;
    for (int n = 0; n < 100 && ids.size() < 12; n++) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) ids.push_back(bus.rsp_id);
    end
    tick();
    bus.req_valid = '0;
    chk("rr_count", 32'(ids.size()), 32'd12);
    for (int i = 0; i < ids.size(); i++) chk("rr_order", 32'(ids[i]), 32'(i % NREQ));

    // Backpressure while requesters 1 and 2 wait.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0110;
    wait_rsp_valid("bp");
    hold_s = bus.rsp_s;
    hold_id = bus.rsp_id;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_s_stable", 32'(bus.rsp_s), 32'(hold_s));
      chk("bp_id_stable", 32'(bus.rsp_id), 32'd1);
      chk("bp_busy", 32'(bus.busy), 32'd1);
      chk("bp_no_grant", 32'(bus.req_ready), 32'd0);
      tick(); @(negedge clk);
    end
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("bp_next_grant", 32'(bus.req_ready), 32'b0100);
    tick();
    bus.req_valid = '0;
    repeat (4) tick();

    // Reset during EXEC; pointer is 3 beforehand.
    bus.req_valid = 4'b1000;
    @(negedge clk);
    chk("rx_grant", 32'(bus.req_ready), 32'b1000);
    tick();
    bus.req_valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req_valid = 4'b1010;
    @(negedge clk);
    chk("rx_cleared", 32'({bus.rsp_valid, bus.busy, bus.add_a, bus.add_b, bus.add_cin,
                            bus.rsp_s, bus.rsp_id}), 32'd0);
    chk("rx_grant_low", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid = '0;
    repeat (4) tick();

    // Reset during RESP; pointer is 2 beforehand.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1000;
    wait_rsp_valid("rr_resp");
    tick();
    bus.req_valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req_valid = 4'b1010;
    @(negedge clk);
    chk("rr_cleared", 32'({bus.rsp_valid, bus.busy, bus.rsp_s, bus.rsp_id, bus.rsp_cout,
                            bus.rsp_ovf}), 32'd0);
    chk("rr_grant_low", 32'(bus.req_ready), 32'b0010);
    bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = '0;
    repeat (4) tick();

    // Random traffic; a requester refreshes its operands only when idle or just granted.
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] || last_ready[i]) begin
          bus.req_valid[i]    = ($urandom % 3 == 0);
          bus.req_a[i*8 +: 8] = pick8();
          bus.req_b[i*8 +: 8] = pick8();
          bus.req_op[i]       = 1'($urandom);
        end else if ($urandom % 10 == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.rsp_ready = ($urandom % 4 != 0);
      rst_n = ($urandom % 200 != 0);
    end
    tick();
    rst_n = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (6) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
